uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer_if.sv | 25 ++
 rtl/uart_rx_framer.sv | 131 +++++++++++++
 tb/tb_uart_rx_framer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framer_if.sv
// Receive-side signal bundle for uart_rx_framer: serial line and consumer enable in,
// delivered byte plus done/error pulses out.
interface uart_rx_framer_if;
  logic       rx_pin;
  logic       rx_en_sig;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       frame_err;

  modport master (
    input  rx_pin,
    input  rx_en_sig,
    output rx_done,
    output rx_data,
    output frame_err
  );

  modport slave (
    output rx_pin,
    output rx_en_sig,
    input  rx_done,
    input  rx_data,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: synchronizes rx_pin, mid-bit samples each bit at BAUD_DIV
// clocks per bit, and reports a good byte (rx_done) or a bad stop bit (frame_err).
module uart_rx_framer #(
  parameter int BAUD_DIV = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_rx_framer_if.master rx
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          sync1;
  logic          sync2;
  logic          line_prev;
  logic          line;
  logic          fall;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [7:0]    data_q;
  logic          done_q;
  logic          err_q;
  logic          sample_bit;
  logic          load_byte;
  logic          set_err;

  assign line = sync2;
  assign fall = line_prev & ~line;

  // Synchronizer and edge-detect flops reset to 1 so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= rx.rx_pin;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Losing the consumer enable mid-frame abandons the frame without any pulse.
  always_comb begin
    state_n    = state;
    sample_bit = 1'b0;
    load_byte  = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (fall && rx.rx_en_sig) state_n = START;
      end
      START: begin
        if (!rx.rx_en_sig)          state_n = IDLE;
        else if (cnt == HALF_LAST)  state_n = line ? IDLE : DATA;
      end
      DATA: begin
        if (!rx.rx_en_sig) begin
          state_n = IDLE;
        end else if (cnt == BIT_LAST) begin
          sample_bit = 1'b1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (!rx.rx_en_sig) begin
          state_n = IDLE;
        end else if (cnt == BIT_LAST) begin
          if (line) begin
            load_byte = 1'b1;
            state_n   = IDLE;
          end else begin
            set_err = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The baud counter restarts on every state change and after each data sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_n != state || state == IDLE || state == WAIT_HIGH || sample_bit)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != DATA)  bit_cnt <= 3'd0;
      else if (sample_bit) bit_cnt <= bit_cnt + 3'd1;

      if (sample_bit) shift_reg <= {line, shift_reg[7:1]};
      if (load_byte)  data_q    <= shift_reg;

      done_q <= load_byte;
      err_q  <= set_err;
    end
  end

  assign rx.rx_done   = done_q;
  assign rx.rx_data   = data_q;
  assign rx.frame_err = err_q;
endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: stimulus queues expected bytes/errors with their
// due cycle; a monitor pops them whenever rx_done or frame_err fires.
module tb_uart_rx_framer;
  localparam int BAUD = 16;
  // Cycles from driving the start bit (at a falling clk edge) to the sampled rx_done.
  localparam int LAT  = BAUD / 2 + 9 * BAUD + 3;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  probe;
  logic  end_req;
  int    cyc = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  exp_t  exp_q[$];

  uart_rx_framer_if rxif();

  uart_rx_framer #(.BAUD_DIV(BAUD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rxif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp, input int tol);
    int diff;
    total_cnt++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) pass_cnt++;
    else $display("[TB] FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic idleBits(input int n);
    rxif.rx_pin = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  task automatic pulseProbe();
    @(posedge clk);
    #1 probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
    @(negedge clk);
  endtask

  // Sends one frame bit by bit; optional enable drop, reset window and drop-on-done.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input bit expect_evt,
                               input int drop_en_bit, input int rst_from_bit, input int rst_to_bit,
                               input bit drop_on_done);
    logic [9:0] frame;
    exp_t       e;
    frame = {stop_val, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == drop_en_bit) rxif.rx_en_sig = 1'b0;
      rxif.rx_pin = frame[i];
      if (i == 0 && expect_evt) begin
        e.is_err = ~stop_val;
        e.data   = data;
        e.cyc    = 32'(cyc + LAT);
        exp_q.push_back(e);
      end
      for (int c = 0; c < BAUD; c++) begin
        @(negedge clk);
        if (drop_on_done && rxif.rx_done) rxif.rx_en_sig = 1'b0;
        if (c == 8 && (i == rst_from_bit || i == rst_to_bit)) begin
          @(posedge clk);
          #2 rst_n = (i == rst_to_bit);
        end
      end
    end
  endtask

  // Monitor: sole owner of the counters and the held-data model.
  initial begin
    exp_t e;
    logic prev_evt;
    logic [7:0] exp_held;
    prev_evt = 1'b0;
    exp_held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_held = 8'h00;
        checkOutput("reset_rx_data", int'(rxif.rx_data), 0, 0);
        checkOutput("reset_rx_done", int'(rxif.rx_done), 0, 0);
        checkOutput("reset_frame_err", int'(rxif.frame_err), 0, 0);
      end else begin
        if (rxif.rx_done || rxif.frame_err) begin
          checkOutput("done_err_exclusive", int'(rxif.rx_done & rxif.frame_err), 0, 0);
          checkOutput("pulse_width", int'(prev_evt), 0, 0);
          checkOutput("event_expected", int'(exp_q.size() != 0), 1, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("event_kind_err", int'(rxif.frame_err), int'(e.is_err), 0);
            if (!e.is_err) exp_held = e.data;
            checkOutput("rx_data", int'(rxif.rx_data), int'(exp_held), 0);
            checkOutput("latency", cyc, int'(e.cyc), 1);
          end
        end
        if (probe) checkOutput("held_rx_data", int'(rxif.rx_data), int'(exp_held), 0);
        if (end_req) begin
          checkOutput("pending_events", exp_q.size(), 0, 0);
          $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
          $finish;
        end
      end
      prev_evt = rxif.rx_done | rxif.frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required $finish, passed %0d of %0d",
             pass_cnt, total_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b1;
    probe          = 1'b0;
    end_req        = 1'b0;
    rxif.rx_pin    = 1'b1;
    rxif.rx_en_sig = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idleBits(1);

    applyStimulus(8'hA5, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    idleBits(1);
    applyStimulus(8'h00, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    idleBits(1);

    applyStimulus(8'h3C, 1'b0, 1'b1, -1, -1, -1, 1'b0);
    idleBits(2);
    applyStimulus(8'h11, 1'b1, 1'b1, -1, -1, -1, 1'b1);
    idleBits(1);
    rxif.rx_en_sig = 1'b1;
    pulseProbe();

    rxif.rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    idleBits(3);
    pulseProbe();

    rxif.rx_en_sig = 1'b0;
    applyStimulus(8'h55, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    idleBits(1);
    rxif.rx_en_sig = 1'b1;
    idleBits(1);
    applyStimulus(8'h55, 1'b1, 1'b0, 4, -1, -1, 1'b0);
    idleBits(1);
    rxif.rx_en_sig = 1'b1;
    idleBits(1);
    pulseProbe();
    applyStimulus(8'h81, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    idleBits(1);

    // Reset is released during d6 (line high) so no spurious edge follows it.
    applyStimulus(8'hC3, 1'b1, 1'b0, -1, 4, 7, 1'b0);
    idleBits(1);
    pulseProbe();
    applyStimulus(8'h7E, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    idleBits(2);

    @(posedge clk);
    #1 end_req = 1'b1;
  end
endmodule
